// File: rtl/m0m1_share_sched.sv
// rtl/m0m1_share_sched.sv - round-robin time-share of one M0/M1 diffusion unit between F0 and F1
module m0m1_share_sched #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f0_valid,
  input  logic [31:0] f0_data,
  output logic        f0_ready,
  input  logic        f1_valid,
  input  logic [31:0] f1_data,
  output logic        f1_ready,
  output logic [7:0]  dm_x0,
  output logic [7:0]  dm_x1,
  output logic [7:0]  dm_x2,
  output logic [7:0]  dm_x3,
  output logic        dm_sel,
  input  logic [31:0] dm_out,
  output logic        f0_res_valid,
  output logic [31:0] f0_res,
  input  logic        f0_res_ready,
  output logic        f1_res_valid,
  output logic [31:0] f1_res,
  input  logic        f1_res_ready,
  output logic        busy
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t      state, state_nxt;
  logic [31:0] op_reg;
  logic [31:0] res0_reg, res1_reg;
  logic        sel_reg, owner, rr_ptr;
  logic        res0_vld, res1_vld;
  logic        e0, e1, grant;

  // A full result buffer blocks its requester even if it drains this same cycle.
  always_comb begin
    e0        = f0_valid && !res0_vld;
    e1        = f1_valid && !res1_vld;
    grant     = (e0 && e1) ? rr_ptr : e1;
    f0_ready  = 1'b0;
    f1_ready  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        f0_ready = e0 && !grant;
        f1_ready = e1 && grant;
        if (f0_ready || f1_ready) state_nxt = ISSUE;
      end
      ISSUE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_reg   <= 32'h0;
      sel_reg  <= 1'b0;
      owner    <= 1'b0;
      rr_ptr   <= PRIO_INIT;
      res0_reg <= 32'h0;
      res1_reg <= 32'h0;
      res0_vld <= 1'b0;
      res1_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      if (f0_valid && f0_ready) begin
        op_reg  <= f0_data;
        sel_reg <= 1'b0;
        owner   <= 1'b0;
      end else if (f1_valid && f1_ready) begin
        op_reg  <= f1_data;
        sel_reg <= 1'b1;
        owner   <= 1'b1;
      end
      if (res0_vld && f0_res_ready) res0_vld <= 1'b0;
      if (res1_vld && f1_res_ready) res1_vld <= 1'b0;
      // Capture never collides with a drain: the owner's buffer was empty at grant.
      if (state == ISSUE) begin
        if (owner) begin
          res1_reg <= dm_out;
          res1_vld <= 1'b1;
        end else begin
          res0_reg <= dm_out;
          res0_vld <= 1'b1;
        end
        rr_ptr <= ~owner;
      end
    end
  end

  assign dm_x0        = op_reg[31:24];
  assign dm_x1        = op_reg[23:16];
  assign dm_x2        = op_reg[15:8];
  assign dm_x3        = op_reg[7:0];
  assign dm_sel       = sel_reg;
  assign busy         = (state == ISSUE);
  assign f0_res_valid = res0_vld;
  assign f0_res       = res0_reg;
  assign f1_res_valid = res1_vld;
  assign f1_res       = res1_reg;

endmodule

// File: doc/m0m1_share_sched.md
# m0m1_share_sched

Scheduler that time-shares one combinational M0/M1 diffusion unit between the F0 and F1 function paths of the CLEFIA round datapath. Each path presents a 32-bit post-S-box word with a valid/ready handshake. The block arbitrates round-robin, drives the shared unit's byte inputs and matrix select, and captures the diffused word into a one-entry result buffer per requester. That buffer is returned over a second valid/ready handshake. It sits between the S-box layer and the Feistel XOR stage.

## Interface
- PRIO_INIT, 0: requester favoured by the round-robin pointer after reset. 0 = F0, 1 = F1.
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- f0_valid  in  1  F0 operand valid
- f0_data  in  32  F0 operand; [31:24]=T0, [23:16]=T1, [15:8]=T2, [7:0]=T3
- f0_ready  out  1  F0 operand accepted this cycle
- f1_valid, f1_data, f1_ready: same as the F0 ports, for F1
- dm_x0, dm_x1, dm_x2, dm_x3  out  8 each  bytes to the shared unit; dm_x0 = op_reg[31:24] … dm_x3 = op_reg[7:0]
- dm_sel  out  1  matrix select to the shared unit; 0 = M0 (F0), 1 = M1 (F1)
- dm_out  in  32  diffused word from the shared unit; [31:24]=Y0 … [7:0]=Y3
- f0_res_valid  out  1  F0 result buffer full
- f0_res  out  32  F0 result
- f0_res_ready  in  1  F0 consumer accepts the result
- f1_res_valid, f1_res, f1_res_ready: same as the F0 result ports, for F1
- busy  out  1  high while in ISSUE

## Operation
- Registers:
  - op_reg[31:0], sel_reg, owner (1 bit), rr_ptr.
  - State: IDLE or ISSUE.
  - Per requester: res_reg[31:0] and res_vld.
- Eligibility: eN = fN_valid && !fN_res_valid. A requester whose result buffer is full is never granted, even if that buffer drains in the same cycle.
- Grant, evaluated in IDLE only:
  - If exactly one requester is eligible, grant it.
  - If both are eligible, grant rr_ptr.
  - If none is eligible, stay in IDLE.
- fN_ready = (state==IDLE) && grant==N && eN. It is combinational and never high for both requesters.
- Accept (fN_valid && fN_ready):
  - op_reg <= fN_data.
  - sel_reg <= N. F0 always uses M0; F1 always uses M1.
  - owner <= N.
  - state <= ISSUE.
- ISSUE (exactly one cycle):
  - dm_x*/dm_sel are driven from op_reg/sel_reg.
  - At the clock edge: res_reg[owner] <= dm_out; res_vld[owner] <= 1; rr_ptr <= ~owner; state <= IDLE.
- dm_x*/dm_sel always reflect op_reg/sel_reg. They keep their last values in IDLE.
- Result drain: fN_res_valid && fN_res_ready clears res_vld[N] at the edge. fN_res holds its value until the next capture.
- FSM transitions:
  - IDLE → ISSUE on any accept; otherwise IDLE → IDLE.
  - ISSUE → IDLE unconditionally.
- No arithmetic. The block is pure muxing and registering; widths are fixed at 32/8 bits.

## Timing
- Reset (rst_n low at an edge):
  - state = IDLE; op_reg = 0; sel_reg = 0; owner = 0; rr_ptr = PRIO_INIT.
  - res_reg = 0; res_vld = 0.
  - Resulting outputs: all ready/res_valid/busy = 0, all data = 0, dm_sel = 0.
- Reset asserted during ISSUE aborts the operation. No result is captured, and the aborted operand is not replayed.
- Latency: accept at edge N → ISSUE during cycle N..N+1 → fN_res_valid = 1 after edge N+1.
- Throughput: one operation every 2 cycles overall. Under continuous demand with prompt draining, F0 and F1 alternate.
- The result buffer holds its value while res_ready is low. The requester stays ineligible until the drain edge; it can be re-granted in the cycle after the drain.
- Simultaneous events:
  - Drain of F0 and capture for F1 at the same edge are independent.
  - A drain and a capture never target the same buffer, because a grant requires an empty buffer.
- Combinational path dm_x → shared unit → dm_out must close in one cycle. The block adds only a register at each end.

## Test plan
- Reset, then F0 alone: after rst_n goes high, f0_data = 0x01000000 → dm_sel = 0; f0_res_valid rises 2 cycles after accept; f0_res = 0x01020406.
- F1 alone: f1_data = 0x01000000 → dm_sel = 1; f1_res = 0x0108020A, 2 cycles after accept.
- Contention: both valid continuously, res_ready tied high, PRIO_INIT = 0 → grants go F0, F1, F0, F1 on alternate cycles; no ready overlap.
- Backpressure: f0_res_ready = 0 with f0_valid held → exactly one F0 capture; f0_ready stays low; F1 is still served. Raising f0_res_ready → drain, then an F0 re-grant on the following cycle.
- Reset mid-ISSUE: assert rst_n = 0 in the ISSUE cycle of an F1 op → f1_res_valid stays 0; all outputs are 0 next cycle; rr_ptr = PRIO_INIT.
- PRIO_INIT = 1 with both requesters valid in the first idle cycle → F1 is granted first.
